// File: rtl/sigma_delta_adc_if.sv
//------------------------------------------------------------------------------
// Module   : sigma_delta_adc_if
// Purpose  : Signal bundle between the sigma-delta ADC receiver and its
//            analogue front end / sample consumer.
// Signals  : CmpIn       comparator output (asynchronous to Clk)
//            FbOut       1-bit feedback to the RC integrator
//            Sample      last decimated sample (WIDTH bits, unsigned)
//            SampleValid one-cycle strobe when Sample updates
//            EarBit      digital EAR level
// Modports : master - the ADC receiver, slave - the environment side
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sigma_delta_adc_if #(
    parameter int WIDTH = 8
);
    logic             CmpIn;
    logic             FbOut;
    logic [WIDTH-1:0] Sample;
    logic             SampleValid;
    logic             EarBit;

    modport master (
        input  CmpIn,
        output FbOut,
        output Sample,
        output SampleValid,
        output EarBit
    );

    modport slave (
        output CmpIn,
        input  FbOut,
        input  Sample,
        input  SampleValid,
        input  EarBit
    );
endinterface

`default_nettype wire

// File: rtl/sigma_delta_adc.sv
//------------------------------------------------------------------------------
// Module   : sigma_delta_adc
// Purpose  : First-order 1-bit sigma-delta ADC receiver for the EAR input.
//            An external comparator and RC integrator close the loop through
//            FbOut. The FbOut bit density is counted over 2^OSR_LOG2 clocks
//            and reduced to a WIDTH-bit unsigned sample with a valid strobe.
//            A digital EAR level is derived from each new sample.
// Ports    : Clk        system clock, rising edge
//            Reset      asynchronous, active-high reset
//            bus        sigma_delta_adc_if.master (CmpIn, FbOut, Sample,
//                       SampleValid, EarBit)
// Config   : SDADC_EAR_HYST_EN - when defined, EarBit uses HYST_HI/HYST_LO
//            hysteresis; otherwise EarBit follows the sample MSB.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sigma_delta_adc #(
    parameter int               OSR_LOG2 = 10,
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] HYST_HI  = 8'hA0,
    parameter logic [WIDTH-1:0] HYST_LO  = 8'h60
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    sigma_delta_adc_if.master  bus
);

    localparam logic [OSR_LOG2-1:0] C_WIN_ONE  = {{(OSR_LOG2-1){1'b0}}, 1'b1};
    localparam logic [OSR_LOG2-1:0] C_WIN_LAST = {OSR_LOG2{1'b1}};
    localparam logic [WIDTH-1:0]    C_MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

    // Synchroniser and feedback register
    logic                cmp_s1_q;
    logic                cmp_s2_q;
    logic                fb_q;

    // Decimation window
    logic [OSR_LOG2-1:0] win_cnt_q;
    logic [OSR_LOG2:0]   acc_q;
    logic [OSR_LOG2:0]   acc_d;

    // Outputs
    logic [WIDTH-1:0]    sample_q;
    logic [WIDTH-1:0]    sample_d;
    logic                valid_q;
    logic                ear_q;
    logic                ear_d;

    logic                w_win_end;
    logic [OSR_LOG2:0]   w_tot;
    logic [OSR_LOG2-1:0] w_sat;

    assign w_win_end = (win_cnt_q == C_WIN_LAST);

    // The final cycle's feedback bit is folded in here rather than in acc_q,
    // so the window total is available on the strobe edge itself.
    assign w_tot = acc_q + {{OSR_LOG2{1'b0}}, fb_q};

    // A window of all ones counts 2^N, which does not fit N bits; clamp it so
    // full scale maps to all-ones rather than wrapping to zero.
    assign w_sat = w_tot[OSR_LOG2] ? {OSR_LOG2{1'b1}} : w_tot[OSR_LOG2-1:0];

    always_comb begin
        acc_d    = acc_q + {{OSR_LOG2{1'b0}}, fb_q};
        sample_d = sample_q;
        ear_d    = ear_q;
        if (w_win_end) begin
            acc_d    = '0;
            // Keep the top WIDTH bits: truncating right shift by OSR_LOG2-WIDTH.
            sample_d = w_sat[OSR_LOG2-1 -: WIDTH];
`ifdef SDADC_EAR_HYST_EN
            if (sample_d >= HYST_HI) begin
                ear_d = 1'b1;
            end else if (sample_d <= HYST_LO) begin
                ear_d = 1'b0;
            end
`else
            ear_d    = sample_d[WIDTH-1];
`endif
        end
    end

`ifndef SDADC_EAR_HYST_EN
    // Thresholds only matter for the hysteresis build.
    logic unused_hyst;
    assign unused_hyst = ^{HYST_HI, HYST_LO};
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cmp_s1_q  <= 1'b0;
            cmp_s2_q  <= 1'b0;
            fb_q      <= 1'b0;
            win_cnt_q <= '0;
            acc_q     <= '0;
            sample_q  <= C_MIDSCALE;
            valid_q   <= 1'b0;
            ear_q     <= 1'b0;
        end else begin
            cmp_s1_q  <= bus.CmpIn;
            cmp_s2_q  <= cmp_s1_q;
            // Inverted so a low comparator (integrator below threshold)
            // drives charge back into the integrator.
            fb_q      <= ~cmp_s2_q;
            win_cnt_q <= win_cnt_q + C_WIN_ONE;
            acc_q     <= acc_d;
            sample_q  <= sample_d;
            valid_q   <= w_win_end;
            ear_q     <= ear_d;
        end
    end

    assign bus.FbOut       = fb_q;
    assign bus.Sample      = sample_q;
    assign bus.SampleValid = valid_q;
    assign bus.EarBit      = ear_q;

endmodule

`default_nettype wire

// File: tb/tb_sigma_delta_adc.sv
//------------------------------------------------------------------------------
// Module   : tb_sigma_delta_adc
// Purpose  : Self-checking bench for sigma_delta_adc (OSR_LOG2=10, WIDTH=8).
//            A window-level model predicts FbOut, Sample, SampleValid and
//            EarBit every cycle; directed scenarios add literal expectations.
// Config   : honours SDADC_EAR_HYST_EN like the design.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sigma_delta_adc;

    localparam int WIN = 1024;

    logic Clk;
    logic Reset;

    sigma_delta_adc_if #(.WIDTH(8)) bus ();

    sigma_delta_adc #(
        .OSR_LOG2 (10),
        .WIDTH    (8),
        .HYST_HI  (8'hA0),
        .HYST_LO  (8'h60)
    ) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    //--------------------------------------------------------------------------
    // Reference model: FbOut after edge n is the inverse of CmpIn as sampled
    // two edges earlier (pre-reset history reads as 0). Each window counts the
    // feedback ones over 1024 edges; the sample is min(count,1023)/4.
    //--------------------------------------------------------------------------
    bit       m_on = 0;
    int       m_edges;
    int       m_ones;
    bit       m_hist[$];
    bit       m_fb;
    bit [7:0] m_sample;
    bit       m_valid;
    bit       m_ear;

    function automatic bit ear_rule(input bit [7:0] s, input bit prev);
`ifdef SDADC_EAR_HYST_EN
        if (s >= 8'hA0) return 1'b1;
        if (s <= 8'h60) return 1'b0;
        return prev;
`else
        return s[7];
`endif
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_edges  = 0;
            m_ones   = 0;
            m_hist   = '{1'b0, 1'b0};
            m_fb     = 1'b0;
            m_sample = 8'h80;
            m_valid  = 1'b0;
            m_ear    = 1'b0;
        end else begin
            m_edges++;
            m_ones += int'(m_fb);
            m_valid = 1'b0;
            if (m_edges % WIN == 0) begin
                m_sample = 8'((m_ones > WIN - 1 ? WIN - 1 : m_ones) / 4);
                m_ear    = ear_rule(m_sample, m_ear);
                m_valid  = 1'b1;
                m_ones   = 0;
            end
            m_hist.push_back(bus.CmpIn);
            m_fb = ~m_hist.pop_front();
        end
    end

    always @(negedge Clk) begin
        if (m_on) begin
            check("FbOut",       int'(bus.FbOut),       int'(m_fb));
            check("SampleValid", int'(bus.SampleValid), int'(m_valid));
            check("Sample",      int'(bus.Sample),      int'(m_sample));
            check("EarBit",      int'(bus.EarBit),      int'(m_ear));
        end
    end

    //--------------------------------------------------------------------------
    // Comparator driver: 0 const-0, 1 const-1, 2 periodic k zeros per 1024,
    // 3 ideal RC integrator at Vin=50%, 4 random.
    //--------------------------------------------------------------------------
    int mode  = 0;
    int pat_k = 0;
    int ph    = 0;
    int rc_x  = 0;

    always @(negedge Clk) begin
        case (mode)
            0: bus.CmpIn = 1'b0;
            1: bus.CmpIn = 1'b1;
            2: begin
                bus.CmpIn = (ph < pat_k) ? 1'b0 : 1'b1;
                ph = (ph + 1) % WIN;
            end
            3: begin
                rc_x += bus.FbOut ? 1 : -1;
                bus.CmpIn = (rc_x > 0);
            end
            default: bus.CmpIn = 1'($urandom_range(0, 1));
        endcase
    end

    // Asserts reset between edges, checks reset values at once, releases on
    // a falling edge.
    task automatic do_reset();
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("rst_FbOut",       int'(bus.FbOut),       0);
        check("rst_Sample",      int'(bus.Sample),      8'h80);
        check("rst_SampleValid", int'(bus.SampleValid), 0);
        check("rst_EarBit",      int'(bus.EarBit),      0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Counts rising edges until a strobe is seen, bounded.
    task automatic wait_strobe(output int cyc);
        cyc = 0;
        do begin
            @(posedge Clk);
            cyc++;
            @(negedge Clk);
        end while (!bus.SampleValid && cyc < 3000);
        if (!bus.SampleValid) check("strobe_timeout", cyc, WIN);
    endtask

    int cyc;
    logic [7:0] t5_s [4];
    bit         t5_e [4];
    logic [7:0] t4_s [3];
    int         t4_k [3];

    initial begin
        t4_k = '{512, 256, 1000};
        t4_s = '{8'h80, 8'h40, 8'hFA};
        t5_s = '{8'h90, 8'hB0, 8'h70, 8'h50};
`ifdef SDADC_EAR_HYST_EN
        t5_e = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
        t5_e = '{1'b1, 1'b1, 1'b0, 0};
`endif
        Reset = 1'b0;
        bus.CmpIn = 1'b0;
        #1 Reset = 1'b1;
        @(negedge Clk);
        m_on = 1;
        @(negedge Clk);
        Reset = 1'b0;

        // Mid-run async reset, then strobe timing and full-scale saturation.
        mode = 0;
        repeat (300) @(negedge Clk);
        do_reset();
        wait_strobe(cyc);
        check("first_strobe_edge", cyc, WIN);
        check("t2_first_window", int'(bus.Sample), 8'hFF);
        wait_strobe(cyc);
        check("strobe_spacing", cyc, WIN);
        check("t2_saturated", int'(bus.Sample), 8'hFF);
        check("t2_ear", int'(bus.EarBit), 1);

        // Comparator held high: zero scale.
        mode = 1;
        do_reset();
        wait_strobe(cyc);
        wait_strobe(cyc);
        check("t3_sample", int'(bus.Sample), 8'h00);
        check("t3_ear", int'(bus.EarBit), 0);

        // Periodic patterns: any 1024 consecutive edges hold exactly k zeros.
        for (int i = 0; i < 3; i++) begin
            ph = 0; pat_k = t4_k[i]; mode = 2;
            wait_strobe(cyc);
            wait_strobe(cyc);
            check("t4_sample", int'(bus.Sample), int'(t4_s[i]));
        end

        // EarBit sequence.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ph = 0; pat_k = int'(t5_s[i]) * 4; mode = 2;
            wait_strobe(cyc);
            wait_strobe(cyc);
            check("t5_sample", int'(bus.Sample), int'(t5_s[i]));
            check("t5_ear", int'(bus.EarBit), int'(t5_e[i]));
        end

        // Reset in the middle of a window.
        mode = 0;
        do_reset();
        repeat (500) @(negedge Clk);
        do_reset();
        check("t6_sample_held", int'(bus.Sample), 8'h80);
        wait_strobe(cyc);
        check("t6_strobe_edge", cyc, WIN);

        // Closed loop with an ideal integrator at half scale.
        rc_x = 0; mode = 3;
        do_reset();
        repeat (4) wait_strobe(cyc);
        check("rc_midscale", int'(bus.Sample >= 8'h7F && bus.Sample <= 8'h81), 1);

        // Random comparator activity with a random mid-window reset.
        mode = 4;
        repeat (2) wait_strobe(cyc);
        repeat ($urandom_range(100, 900)) @(negedge Clk);
        do_reset();
        repeat (2) wait_strobe(cyc);
        check("rand_strobe_spacing", cyc, WIN);

        repeat (3) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
